// File: rtl/active_pixel_pingpong.sv
// Double-buffered pixel-map memory: the producer writes one bank while the timing path reads the
// other; a request/ack controller swaps the banks and can zero-fill the new write bank.
module active_pixel_pingpong #(
    parameter int unsigned DATA_W        = 1,
    parameter int unsigned ADDR_W        = 9,
    parameter int unsigned DEPTH         = 512,
    parameter bit          CLEAR_ON_SWAP = 1'b1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              ren_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    input  logic              swap_req_i,
    output logic              swap_ack_o,
    output logic              busy_o,
    output logic              wdrop_o,
    output logic              wbank_o,
    output logic [ADDR_W:0]   wcount_o
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] bank0_mem [DEPTH];
    logic [DATA_W-1:0] bank1_mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              wbank_q, wbank_d;
    logic [ADDR_W:0]   wcount_q, wcount_d;
    logic              swap_ack_q, swap_ack_d;
    logic              wdrop_q, wdrop_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_in_range;
    logic              rd_in_range;

    assign wr_in_range = ({1'b0, waddr_i} < DepthW);
    assign rd_in_range = ({1'b0, raddr_i} < DepthW);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wbank_d    = wbank_q;
        wcount_d   = wcount_q;
        swap_ack_d = 1'b0;
        wdrop_d    = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = waddr_i;
        mem_wdata  = wdata_i;

        unique case (state_q)
            StIdle: begin
                if (wen_i) begin
                    if (wr_in_range) begin
                        mem_we = 1'b1;
                        if (wcount_q != DepthW) begin
                            wcount_d = wcount_q + (ADDR_W + 1)'(1);
                        end
                    end else begin
                        wdrop_d = 1'b1;
                    end
                end
                // A same-edge write still lands in the old bank because the bank flop updates after.
                if (swap_req_i) begin
                    wbank_d    = ~wbank_q;
                    swap_ack_d = 1'b1;
                    wcount_d   = '0;
                    if (CLEAR_ON_SWAP) begin
                        state_d   = StClear;
                        clr_cnt_d = '0;
                    end
                end
            end
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                wdrop_d   = wen_i;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LastAddr) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        rvalid_d = ren_i;
        rdata_d  = rdata_q;
        if (ren_i) begin
            if (!rd_in_range) begin
                rdata_d = '0;
            end else if (wbank_q) begin
                rdata_d = bank0_mem[raddr_i];
            end else begin
                rdata_d = bank1_mem[raddr_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            clr_cnt_q  <= '0;
            wbank_q    <= 1'b0;
            wcount_q   <= '0;
            swap_ack_q <= 1'b0;
            wdrop_q    <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wbank_q    <= wbank_d;
            wcount_q   <= wcount_d;
            swap_ack_q <= swap_ack_d;
            wdrop_q    <= wdrop_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Banks carry no reset; only the write strobe is held off while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (rstn_i && mem_we) begin
            if (wbank_q) begin
                bank1_mem[mem_waddr] <= mem_wdata;
            end else begin
                bank0_mem[mem_waddr] <= mem_wdata;
            end
        end
    end

    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;
    assign swap_ack_o = swap_ack_q;
    assign busy_o     = (state_q == StClear);
    assign wdrop_o    = wdrop_q;
    assign wbank_o    = wbank_q;
    assign wcount_o   = wcount_q;

endmodule

// File: tb/tb_active_pixel_pingpong.sv
// Directed bench: a DEPTH=512 clearing instance for swap/clear behaviour and a DEPTH=300
// non-clearing instance for address and count boundaries.
module tb_active_pixel_pingpong;

    logic       clk;
    logic       rstn;
    logic [8:0] waddr, raddr;
    logic       wdata, wen, ren, swap_req;
    logic       rdata, rvalid, swap_ack, busy, wdrop, wbank;
    logic [9:0] wcount;

    logic [8:0] b_waddr, b_raddr;
    logic       b_wdata, b_wen, b_ren, b_swap_req;
    logic       b_rdata, b_rvalid, b_swap_ack, b_busy, b_wdrop, b_wbank;
    logic [9:0] b_wcount;

    int n_cmp = 0;
    int n_err = 0;

    active_pixel_pingpong #(
        .DATA_W(1), .ADDR_W(9), .DEPTH(512), .CLEAR_ON_SWAP(1'b1)
    ) u_dut (
        .clk_i(clk), .rstn_i(rstn), .waddr_i(waddr), .wdata_i(wdata), .wen_i(wen),
        .raddr_i(raddr), .ren_i(ren), .rdata_o(rdata), .rvalid_o(rvalid),
        .swap_req_i(swap_req), .swap_ack_o(swap_ack), .busy_o(busy), .wdrop_o(wdrop),
        .wbank_o(wbank), .wcount_o(wcount)
    );

    active_pixel_pingpong #(
        .DATA_W(1), .ADDR_W(9), .DEPTH(300), .CLEAR_ON_SWAP(1'b0)
    ) u_dut_b (
        .clk_i(clk), .rstn_i(rstn), .waddr_i(b_waddr), .wdata_i(b_wdata), .wen_i(b_wen),
        .raddr_i(b_raddr), .ren_i(b_ren), .rdata_o(b_rdata), .rvalid_o(b_rvalid),
        .swap_req_i(b_swap_req), .swap_ack_o(b_swap_ack), .busy_o(b_busy), .wdrop_o(b_wdrop),
        .wbank_o(b_wbank), .wcount_o(b_wcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Raises swap_req until the ack is seen; lat is the number of cycles waited beyond the first.
    task automatic do_swap(output int lat);
        swap_req = 1'b1;
        lat = 0;
        tick();
        while (!swap_ack && lat < 2000) begin
            tick();
            lat++;
        end
        swap_req = 1'b0;
        n_cmp++;
        if (swap_ack !== 1'b1) begin
            n_err++;
            $display("FAIL swap_ack: ack=%0b after %0d cycles, required 1", swap_ack, lat);
        end
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({rdata, rvalid, swap_ack, busy, wdrop, wbank} !== 6'b0 || wcount !== 10'd0) begin
            n_err++;
            $display("FAIL reset_a: rd=%0b rv=%0b ack=%0b busy=%0b drop=%0b wb=%0b wc=%0d, required all 0",
                     rdata, rvalid, swap_ack, busy, wdrop, wbank, wcount);
        end
        n_cmp++;
        if ({b_rdata, b_rvalid, b_swap_ack, b_busy, b_wdrop, b_wbank} !== 6'b0 || b_wcount !== 10'd0) begin
            n_err++;
            $display("FAIL reset_b: wb=%0b wc=%0d ack=%0b, required 0", b_wbank, b_wcount, b_swap_ack);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic_swap();
        wen = 1'b1; waddr = 9'd5; wdata = 1'b1;
        tick();
        wen = 1'b0;
        n_cmp++;
        if (wcount !== 10'd1) begin
            n_err++;
            $display("FAIL basic_wcount: got %0d, required 1", wcount);
        end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        n_cmp++;
        if (swap_ack !== 1'b1 || wbank !== 1'b1 || wcount !== 10'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_swap: ack=%0b wb=%0b wc=%0d busy=%0b, required 1 1 0 1",
                     swap_ack, wbank, wcount, busy);
        end
        ren = 1'b1; raddr = 9'd5;
        tick();
        ren = 1'b0;
        n_cmp++;
        if (swap_ack !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ack_pulse: ack=%0b, required 0", swap_ack);
        end
        n_cmp++;
        if (rdata !== 1'b1 || rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_read: rd=%0b rv=%0b, required 1 1", rdata, rvalid);
        end
        tick();
        n_cmp++;
        if (rdata !== 1'b1 || rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL read_hold: rd=%0b rv=%0b, required 1 0", rdata, rvalid);
        end
        wait_idle();
    endtask

    task automatic test_clear_on_swap();
        int lat, n, bad;
        do_swap(lat);
        busy_len(n);
        n_cmp++;
        if (n != 512) begin
            n_err++;
            $display("FAIL busy_len0: got %0d, required 512", n);
        end
        for (int i = 0; i < 512; i++) begin
            wen = 1'b1; waddr = 9'(i); wdata = 1'b1;
            tick();
        end
        wen = 1'b0;
        n_cmp++;
        if (wcount !== 10'd512 || wbank !== 1'b0) begin
            n_err++;
            $display("FAIL fill_count: wc=%0d wb=%0b, required 512 0", wcount, wbank);
        end
        do_swap(lat);
        busy_len(n);
        n_cmp++;
        if (n != 512) begin
            n_err++;
            $display("FAIL busy_len1: got %0d, required 512", n);
        end
        ren = 1'b1; raddr = 9'd300;
        tick();
        ren = 1'b0;
        n_cmp++;
        if (rdata !== 1'b1) begin
            n_err++;
            $display("FAIL filled_read: rd=%0b, required 1", rdata);
        end
        do_swap(lat);
        busy_len(n);
        n_cmp++;
        if (n != 512 || wbank !== 1'b0) begin
            n_err++;
            $display("FAIL busy_len2: got %0d wb=%0b, required 512 0", n, wbank);
        end
        // Expose bank 0 for reading; the reads overlap the clear of bank 1.
        do_swap(lat);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            ren = 1'b1; raddr = 9'(i);
            tick();
            if (rdata !== 1'b0 || rvalid !== 1'b1) bad++;
        end
        ren = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL cleared_bank: %0d nonzero reads, required 0", bad);
        end
        wait_idle();
    endtask

    task automatic test_swap_during_clear();
        int cyc;
        logic got;
        swap_req = 1'b1;
        tick();
        n_cmp++;
        if (swap_ack !== 1'b1) begin
            n_err++;
            $display("FAIL first_ack: ack=%0b, required 1", swap_ack);
        end
        cyc = 0;
        got = 1'b0;
        waddr = 9'd3; wdata = 1'b1;
        while (cyc < 2000 && !got) begin
            wen = (cyc == 10) || (cyc == 200);
            tick();
            cyc++;
            if (wen) begin
                n_cmp++;
                if (wdrop !== 1'b1 || wcount !== 10'd0) begin
                    n_err++;
                    $display("FAIL clear_drop: drop=%0b wc=%0d, required 1 0", wdrop, wcount);
                end
            end
            got = swap_ack;
        end
        wen = 1'b0;
        swap_req = 1'b0;
        n_cmp++;
        if (cyc != 513) begin
            n_err++;
            $display("FAIL ack_spacing: got %0d, required 513", cyc);
        end
        tick();
        n_cmp++;
        if (wdrop !== 1'b0) begin
            n_err++;
            $display("FAIL drop_pulse: drop=%0b, required 0", wdrop);
        end
        wait_idle();
    endtask

    task automatic test_simultaneous();
        int lat;
        wen = 1'b1; waddr = 9'd7; wdata = 1'b0;
        tick();
        wen = 1'b0;
        do_swap(lat);
        wait_idle();
        wen = 1'b1; waddr = 9'd8; wdata = 1'b1;
        tick();
        n_cmp++;
        if (wcount !== 10'd1) begin
            n_err++;
            $display("FAIL simul_pre_count: wc=%0d, required 1", wcount);
        end
        waddr = 9'd7; ren = 1'b1; raddr = 9'd7; swap_req = 1'b1;
        tick();
        wen = 1'b0; swap_req = 1'b0;
        n_cmp++;
        if (swap_ack !== 1'b1 || rdata !== 1'b0 || rvalid !== 1'b1 || wcount !== 10'd0) begin
            n_err++;
            $display("FAIL simul_edge: ack=%0b rd=%0b rv=%0b wc=%0d, required 1 0 1 0",
                     swap_ack, rdata, rvalid, wcount);
        end
        tick();
        ren = 1'b0;
        n_cmp++;
        if (rdata !== 1'b1 || rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL simul_after: rd=%0b rv=%0b, required 1 1", rdata, rvalid);
        end
        wait_idle();
    endtask

    task automatic test_boundaries();
        b_wen = 1'b1; b_waddr = 9'd1; b_wdata = 1'b1;
        tick();
        b_wen = 1'b0; b_swap_req = 1'b1;
        tick();
        b_swap_req = 1'b0;
        n_cmp++;
        if (b_swap_ack !== 1'b1 || b_wbank !== 1'b1 || b_busy !== 1'b0) begin
            n_err++;
            $display("FAIL b_swap: ack=%0b wb=%0b busy=%0b, required 1 1 0", b_swap_ack, b_wbank, b_busy);
        end
        b_ren = 1'b1; b_raddr = 9'd1;
        tick();
        n_cmp++;
        if (b_rdata !== 1'b1) begin
            n_err++;
            $display("FAIL b_read1: rd=%0b, required 1", b_rdata);
        end
        b_raddr = 9'd511; b_wen = 1'b1; b_waddr = 9'd300;
        tick();
        b_ren = 1'b0; b_wen = 1'b0;
        n_cmp++;
        if (b_rdata !== 1'b0 || b_rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL b_read_oob: rd=%0b rv=%0b, required 0 1", b_rdata, b_rvalid);
        end
        n_cmp++;
        if (b_wdrop !== 1'b1 || b_wcount !== 10'd0) begin
            n_err++;
            $display("FAIL b_write_oob: drop=%0b wc=%0d, required 1 0", b_wdrop, b_wcount);
        end
        for (int i = 0; i < 400; i++) begin
            b_wen = 1'b1; b_waddr = 9'd0; b_wdata = 1'b1;
            tick();
            if (i == 298) begin
                n_cmp++;
                if (b_wcount !== 10'd299) begin
                    n_err++;
                    $display("FAIL b_count299: wc=%0d, required 299", b_wcount);
                end
            end
        end
        b_wen = 1'b0;
        n_cmp++;
        if (b_wcount !== 10'd300 || b_wdrop !== 1'b0) begin
            n_err++;
            $display("FAIL b_saturate: wc=%0d drop=%0b, required 300 0", b_wcount, b_wdrop);
        end
    endtask

    task automatic test_reset_mid_clear();
        int lat;
        do_swap(lat);
        for (int i = 0; i < 100; i++) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_clear_busy: busy=%0b, required 1", busy);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || wbank !== 1'b0 || wcount !== 10'd0 || swap_ack !== 1'b0) begin
            n_err++;
            $display("FAIL mid_clear_reset: busy=%0b wb=%0b wc=%0d ack=%0b, required 0 0 0 0",
                     busy, wbank, wcount, swap_ack);
        end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        n_cmp++;
        if (swap_ack !== 1'b1 || wbank !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_swap: ack=%0b wb=%0b, required 1 1", swap_ack, wbank);
        end
    endtask

    initial begin
        rstn = 1'b0;
        waddr = '0; raddr = '0; wdata = 1'b0; wen = 1'b0; ren = 1'b0; swap_req = 1'b0;
        b_waddr = '0; b_raddr = '0; b_wdata = 1'b0; b_wen = 1'b0; b_ren = 1'b0; b_swap_req = 1'b0;
        test_reset();
        test_basic_swap();
        test_clear_on_swap();
        test_swap_during_clear();
        test_simultaneous();
        test_boundaries();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
